// File: rtl/seq_sig_pkg.sv
// rtl/seq_sig_pkg.sv - shared sequence constants, detector state type and phase helper
package seq_sig_pkg;

  localparam int SEQ_LEN = 12;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 12'hD94;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } det_state_t;

  // Advance a bit index within one period, wrapping after the last bit
  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return (p == 4'(SEQ_LEN - 1)) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - W-bit saturating event counter with async reset
module seq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - 12-bit periodic sequence detector; SEQ_DET_BITERR_EN adds bit_err_cnt
module seq_pattern_detector
  import seq_sig_pkg::*;
#(
  parameter logic [SEQ_LEN-1:0] PATTERN    = SEQ_PATTERN,
  parameter int                 LOCK_CNT   = 2,
  parameter int                 UNLOCK_CNT = 3,
  parameter int                 CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic             locked,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] period_cnt
`ifdef SEQ_DET_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_cnt
`endif
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [3:0] LAST_PH  = 4'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] win;
  logic [SEQ_LEN-1:0] next_win;
  logic               win_hit;
  det_state_t         state;
  logic [3:0]         ph;
  logic [3:0]         ph_nxt;
  logic [3:0]         good;
  logic [3:0]         miss;
  logic               period_end;
  logic               period_inc;

  // Window as it will look once the current bit is shifted in
  assign next_win   = {din, win[SEQ_LEN-1:1]};
  assign win_hit    = (next_win == PATTERN);
  assign ph_nxt     = next_phase(ph);
  assign period_end = din_valid && (ph == LAST_PH);
  assign period_inc = period_end && (state == LOCKED) && win_hit;

  // Shift valid bits into the window and flag every full-pattern window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win   <= '0;
      match <= 1'b0;
    end else begin
      match <= din_valid && win_hit;
      if (din_valid) begin
        win <= next_win;
      end
    end
  end

  // Alignment FSM: hunt for the pattern, verify its period, then track it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      ph     <= 4'd0;
      good   <= 4'd0;
      miss   <= 4'd0;
      locked <= 1'b0;
      phase  <= 4'd0;
    end else if (din_valid) begin
      ph <= ph_nxt;
      case (state)
        HUNT: begin
          locked <= 1'b0;
          phase  <= 4'd0;
          if (win_hit) begin
            state <= VERIFY;
            ph    <= 4'd0;
            good  <= 4'd0;
          end
        end
        VERIFY: begin
          if (ph == LAST_PH) begin
            if (win_hit) begin
              if (good + 4'd1 == LOCK_N) begin
                state  <= LOCKED;
                miss   <= 4'd0;
                locked <= 1'b1;
                phase  <= ph_nxt;
              end else begin
                good <= good + 4'd1;
              end
            end else begin
              state <= HUNT;
            end
          end
        end
        LOCKED: begin
          phase <= ph_nxt;
          if (ph == LAST_PH) begin
            if (win_hit) begin
              miss <= 4'd0;
            end else if (miss + 4'd1 == UNLOCK_N) begin
              state  <= HUNT;
              ph     <= 4'd0;
              locked <= 1'b0;
              phase  <= 4'd0;
            end else begin
              miss <= miss + 4'd1;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          phase  <= 4'd0;
        end
      endcase
    end
  end

  seq_sat_counter #(.W(CNT_W)) u_period_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (period_inc),
    .count (period_cnt)
  );

`ifdef SEQ_DET_BITERR_EN
  logic bit_err;
  assign bit_err = din_valid && (state == LOCKED) && (din != PATTERN[ph]);

  seq_sat_counter #(.W(CNT_W)) u_bit_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_err),
    .count (bit_err_cnt)
  );
`endif

endmodule
